// File: rtl/axil_test_device_pkg.sv
// Shared constants and types for the AXI-Lite bring-up test device.
package axil_test_device_pkg;

    // Byte offsets within the 256-byte register window
    localparam logic [7:0] ADDR_ID           = 8'h00;
    localparam logic [7:0] ADDR_VERSION      = 8'h04;
    localparam logic [7:0] ADDR_CONTROL      = 8'h08;
    localparam logic [7:0] ADDR_CYCLES       = 8'h0C;
    localparam logic [7:0] ADDR_WRCOUNT      = 8'h10;
    localparam logic [7:0] ADDR_SCRATCH_BASE = 8'h20;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    // CONTROL register fields
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;
    localparam int CTRL_OUT_LSB = 8;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    // Merge new data into an existing word, one byte lane per strobe bit
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_test_device_if.sv
// AXI-Lite bus bundle between the bridge (master) and the test device (slave).
interface axil_test_device_if #(
    parameter int C_AXI_ADDR_WIDTH = 32
);
    logic [C_AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
    logic [2:0]                  s_axi_awprot;
    logic                        s_axi_awvalid;
    logic                        s_axi_awready;
    logic [31:0]                 s_axi_wdata;
    logic [3:0]                  s_axi_wstrb;
    logic                        s_axi_wvalid;
    logic                        s_axi_wready;
    logic [1:0]                  s_axi_bresp;
    logic                        s_axi_bvalid;
    logic                        s_axi_bready;
    logic [C_AXI_ADDR_WIDTH-1:0] s_axi_araddr;
    logic [2:0]                  s_axi_arprot;
    logic                        s_axi_arvalid;
    logic                        s_axi_arready;
    logic [31:0]                 s_axi_rdata;
    logic [1:0]                  s_axi_rresp;
    logic                        s_axi_rvalid;
    logic                        s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/axil_test_regfile.sv
// Register bank: address decode, byte-strobed writes, read mux and counters.
module axil_test_regfile
    import axil_test_device_pkg::*;
#(
    parameter int          NUM_SCRATCH = 4,
    parameter logic [31:0] DEVICE_ID   = 32'h4E54_4431,
    parameter logic [31:0] VERSION     = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [5:0]  wr_word,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic        wr_err,
    input  logic [5:0]  rd_word,
    output logic [31:0] rd_data,
    output logic        rd_err,
    output logic [7:0]  ctrl_out
);
    logic [7:0]  wr_off;
    logic [7:0]  rd_off;
    logic        cnt_en;
    logic [31:0] cycles;
    logic [31:0] wrcount;
    logic [31:0] scratch [NUM_SCRATCH];
    logic        ctrl_wr;

    function automatic logic is_mapped(input logic [7:0] off);
        logic hit;
        hit = (off == ADDR_ID) || (off == ADDR_VERSION) || (off == ADDR_CONTROL) ||
              (off == ADDR_CYCLES) || (off == ADDR_WRCOUNT);
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (off == ADDR_SCRATCH_BASE + 8'(4 * i)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign wr_off  = {wr_word, 2'b00};
    assign rd_off  = {rd_word, 2'b00};
    assign wr_err  = !is_mapped(wr_off);
    assign ctrl_wr = wr_en && (wr_off == ADDR_CONTROL);

    // CONTROL fields, cycle counter (clear beats enable) and OKAY-write counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_en   <= 1'b0;
            ctrl_out <= 8'h00;
            cycles   <= 32'h0;
            wrcount  <= 32'h0;
        end else begin
            if (ctrl_wr && wr_strb[0] && wr_data[CTRL_CLR_BIT]) cycles <= 32'h0;
            else if (cnt_en)                                    cycles <= cycles + 32'h1;
            if (ctrl_wr && wr_strb[0]) cnt_en   <= wr_data[CTRL_EN_BIT];
            if (ctrl_wr && wr_strb[1]) ctrl_out <= wr_data[CTRL_OUT_LSB +: 8];
            if (wr_en && !wr_err) wrcount <= wrcount + 32'h1;
        end
    end

    // Scratch registers, written per byte lane
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= 32'h0;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (wr_en && wr_off == ADDR_SCRATCH_BASE + 8'(4 * i))
                    scratch[i] <= apply_wstrb(scratch[i], wr_data, wr_strb);
            end
        end
    end

    // Read mux over current register values; unmapped offsets return the marker word
    always_comb begin
        rd_data = UNMAPPED_RDATA;
        rd_err  = 1'b1;
        case (rd_off)
            ADDR_ID:      begin rd_data = DEVICE_ID; rd_err = 1'b0; end
            ADDR_VERSION: begin rd_data = VERSION;   rd_err = 1'b0; end
            ADDR_CONTROL: begin rd_data = {16'h0, ctrl_out, 7'h0, cnt_en}; rd_err = 1'b0; end
            ADDR_CYCLES:  begin rd_data = cycles;    rd_err = 1'b0; end
            ADDR_WRCOUNT: begin rd_data = wrcount;   rd_err = 1'b0; end
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (rd_off == ADDR_SCRATCH_BASE + 8'(4 * i)) begin
                        rd_data = scratch[i];
                        rd_err  = 1'b0;
                    end
                end
            end
        endcase
    end
endmodule

// File: rtl/axil_test_device.sv
// AXI-Lite test slave: independent write and read channel FSMs around the register bank.
module axil_test_device
    import axil_test_device_pkg::*;
#(
    parameter int          C_AXI_ADDR_WIDTH = 32,
    parameter int          NUM_SCRATCH      = 4,
    parameter logic [31:0] DEVICE_ID        = 32'h4E54_4431,
    parameter logic [31:0] VERSION          = 32'h0001_0000
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    axil_test_device_if.slave     bus,
    output logic [7:0]            ctrl_o
);
    wstate_t     w_state, w_state_n;
    rstate_t     r_state, r_state_n;
    logic        aw_held, aw_held_n, w_held, w_held_n;
    logic        awready_q, awready_n, wready_q, wready_n;
    logic        bvalid_q, bvalid_n;
    logic [1:0]  bresp_q, bresp_n;
    logic        arready_q, arready_n, rvalid_q, rvalid_n;
    logic [31:0] rdata_q, rdata_n;
    logic [1:0]  rresp_q, rresp_n;
    logic [5:0]  aw_word;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_hs, w_hs, ar_hs, wr_en, wr_err, rd_err;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign unused_bits = &{1'b0, bus.s_axi_awprot, bus.s_axi_arprot,
                           bus.s_axi_awaddr[C_AXI_ADDR_WIDTH-1:8], bus.s_axi_awaddr[1:0],
                           bus.s_axi_araddr[C_AXI_ADDR_WIDTH-1:8], bus.s_axi_araddr[1:0]};

    assign aw_hs = bus.s_axi_awvalid && awready_q;
    assign w_hs  = bus.s_axi_wvalid  && wready_q;
    assign ar_hs = bus.s_axi_arvalid && arready_q;

    assign bus.s_axi_awready = awready_q;
    assign bus.s_axi_wready  = wready_q;
    assign bus.s_axi_bvalid  = bvalid_q;
    assign bus.s_axi_bresp   = bresp_q;
    assign bus.s_axi_arready = arready_q;
    assign bus.s_axi_rvalid  = rvalid_q;
    assign bus.s_axi_rdata   = rdata_q;
    assign bus.s_axi_rresp   = rresp_q;

    axil_test_regfile #(
        .NUM_SCRATCH (NUM_SCRATCH),
        .DEVICE_ID   (DEVICE_ID),
        .VERSION     (VERSION)
    ) u_regs (
        .clk      (clk_i),
        .rst      (rstn_i),
        .wr_en    (wr_en),
        .wr_word  (aw_word),
        .wr_data  (wdata_q),
        .wr_strb  (wstrb_q),
        .wr_err   (wr_err),
        .rd_word  (bus.s_axi_araddr[7:2]),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .ctrl_out (ctrl_o)
    );

    // Capture address and data beats as they are accepted; validity lives in aw_held/w_held
    always_ff @(posedge clk_i) begin
        if (aw_hs) aw_word <= bus.s_axi_awaddr[7:2];
        if (w_hs) begin
            wdata_q <= bus.s_axi_wdata;
            wstrb_q <= bus.s_axi_wstrb;
        end
    end

    // Write channel state and registered handshake outputs
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state   <= w_state_n;
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
        end
    end

    // Write channel: collect AW and W in any order, commit once both are held, then respond
    always_comb begin
        w_state_n = w_state;
        aw_held_n = aw_held || aw_hs;
        w_held_n  = w_held  || w_hs;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        wr_en     = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_held && w_held) begin
                    wr_en     = 1'b1;
                    w_state_n = W_RESP;
                    bvalid_n  = 1'b1;
                    bresp_n   = wr_err ? RESP_SLVERR : RESP_OKAY;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    awready_n = 1'b0;
                    wready_n  = 1'b0;
                end else begin
                    awready_n = !aw_held_n;
                    wready_n  = !w_held_n;
                end
            end
            W_RESP: begin
                if (bus.s_axi_bready) begin
                    w_state_n = W_IDLE;
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    // Read channel state and registered response
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state   <= r_state_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rdata_q   <= rdata_n;
            rresp_q   <= rresp_n;
        end
    end

    // Read channel: sample the register bank on the AR handshake, hold until rready
    always_comb begin
        r_state_n = r_state;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rdata_n   = rdata_q;
        rresp_n   = rresp_q;
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (ar_hs) begin
                    r_state_n = R_DATA;
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    rdata_n   = rd_data;
                    rresp_n   = rd_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
            R_DATA: begin
                if (bus.s_axi_rready) begin
                    r_state_n = R_IDLE;
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axil_test_device.sv
// Directed bench for axil_test_device: register map, handshakes, counters, errors, reset abort.
module tb_axil_test_device;
    logic       clk = 1'b0;
    logic       rstn_i;
    logic [7:0] ctrl_o;
    int         n_checks = 0;
    int         n_pass   = 0;

    axil_test_device_if #(.C_AXI_ADDR_WIDTH(32)) bus();

    axil_test_device #(
        .C_AXI_ADDR_WIDTH (32),
        .NUM_SCRATCH      (4),
        .DEVICE_ID        (32'h4E54_4431),
        .VERSION          (32'h0001_0000)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn_i),
        .bus    (bus),
        .ctrl_o (ctrl_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, aw_fire, w_fire, got;
        aw_done = 0; w_done = 0; got = 0;
        resp = 2'bxx;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_wdata   = data;
        bus.s_axi_wstrb   = strb;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            aw_fire = !aw_done && bus.s_axi_awready;
            w_fire  = !w_done  && bus.s_axi_wready;
            step();
            if (aw_fire) begin bus.s_axi_awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin bus.s_axi_wvalid  = 1'b0; w_done  = 1; end
        end
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) check("wr_accept_timeout", 32'd0, 32'd1);
        bus.s_axi_bready = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            if (bus.s_axi_bvalid) begin
                resp = bus.s_axi_bresp;
                got  = 1;
            end
            step();
        end
        bus.s_axi_bready = 1'b0;
        if (!got) check("wr_bvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit done;
        int lat;
        done = 0;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arvalid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            if (bus.s_axi_arready) done = 1;
            step();
        end
        bus.s_axi_arvalid = 1'b0;
        if (!done) check("rd_accept_timeout", 32'd0, 32'd1);
        lat = 1;
        while (!bus.s_axi_rvalid && lat < 20) begin
            step();
            lat++;
        end
        check("rd_latency", 32'(lat), 32'd1);
        data = bus.s_axi_rdata;
        resp = bus.s_axi_rresp;
        bus.s_axi_rready = 1'b1;
        step();
        bus.s_axi_rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d, c1, c2;
        logic [1:0]  r;
        bit          stable;

        rstn_i = 1'b1;
        bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata  = '0; bus.s_axi_wstrb  = '0; bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arprot = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b0;
        repeat (3) step();
        check("rst_awready", 32'(bus.s_axi_awready), 32'd0);
        check("rst_arready", 32'(bus.s_axi_arready), 32'd0);
        check("rst_ctrl_o",  32'(ctrl_o),            32'd0);
        rstn_i = 1'b0;
        check("rel_awready_low", 32'(bus.s_axi_awready), 32'd0);
        step();
        check("rel_awready", 32'(bus.s_axi_awready), 32'd1);
        check("rel_wready",  32'(bus.s_axi_wready),  32'd1);
        check("rel_arready", 32'(bus.s_axi_arready), 32'd1);

        // 1: ID / VERSION, plus upper address bits ignored
        axi_read(32'h00, d, r);
        check("t1_id", d, 32'h4E54_4431);
        check("t1_id_resp", 32'(r), 32'd0);
        axi_read(32'h04, d, r);
        check("t1_ver", d, 32'h0001_0000);
        check("t1_ver_resp", 32'(r), 32'd0);
        axi_read(32'h1234_5604, d, r);
        check("t1_alias", d, 32'h0001_0000);

        // 2: byte-strobed scratch and write counter
        axi_write(32'h20, 32'h1234_5678, 4'hF, r);
        check("t2_wr1_resp", 32'(r), 32'd0);
        axi_write(32'h20, 32'hAAAA_AAAA, 4'b0101, r);
        check("t2_wr2_resp", 32'(r), 32'd0);
        axi_read(32'h20, d, r);
        check("t2_scratch0", d, 32'h12AA_56AA);
        axi_read(32'h10, d, r);
        check("t2_wrcount", d, 32'd2);

        // 3: W ahead of AW, back-pressured response, CONTROL write
        bus.s_axi_wdata  = 32'h0000_A501;
        bus.s_axi_wstrb  = 4'hF;
        bus.s_axi_wvalid = 1'b1;
        check("t3_wready_pre", 32'(bus.s_axi_wready), 32'd1);
        step();
        bus.s_axi_wvalid = 1'b0;
        check("t3_wready_drop", 32'(bus.s_axi_wready), 32'd0);
        step();
        step();
        check("t3_no_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        bus.s_axi_awaddr  = 32'h08;
        bus.s_axi_awvalid = 1'b1;
        check("t3_awready", 32'(bus.s_axi_awready), 32'd1);
        step();
        bus.s_axi_awvalid = 1'b0;
        step();
        check("t3_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
        stable = 1;
        for (int n = 0; n < 4; n++) begin
            if (!bus.s_axi_bvalid || bus.s_axi_bresp != 2'b00) stable = 0;
            step();
        end
        check("t3_bvalid_stable", 32'(stable), 32'd1);
        bus.s_axi_bready = 1'b1;
        step();
        bus.s_axi_bready = 1'b0;
        check("t3_bvalid_drop", 32'(bus.s_axi_bvalid), 32'd0);
        check("t3_awready_back", 32'(bus.s_axi_awready), 32'd1);
        check("t3_ctrl_o", 32'(ctrl_o), 32'hA5);
        axi_read(32'h0C, c1, r);
        axi_read(32'h0C, c2, r);
        check("t3_cycles_inc", 32'(c2 > c1), 32'd1);
        axi_read(32'h08, d, r);
        check("t3_control", d, 32'h0000_A501);

        // 4: clear while counting
        axi_write(32'h08, 32'h0000_0003, 4'hF, r);
        axi_read(32'h0C, c1, r);
        check("t4_cycles_small", 32'(c1 < 32'd10), 32'd1);
        axi_read(32'h0C, c2, r);
        check("t4_cycles_inc", 32'(c2 > c1), 32'd1);
        axi_read(32'h08, d, r);
        check("t4_control", d, 32'h0000_0001);
        check("t4_ctrl_o", 32'(ctrl_o), 32'h00);

        // 5: RO write is OKAY and counted; unmapped write/read give SLVERR
        axi_write(32'h00, 32'hFFFF_FFFF, 4'hF, r);
        check("t5_ro_resp", 32'(r), 32'd0);
        axi_read(32'h00, d, r);
        check("t5_id_kept", d, 32'h4E54_4431);
        axi_write(32'h40, 32'h5555_5555, 4'hF, r);
        check("t5_unmapped_bresp", 32'(r), 32'd2);
        axi_read(32'h10, d, r);
        check("t5_wrcount", d, 32'd5);
        axi_read(32'h20, d, r);
        check("t5_scratch0_kept", d, 32'h12AA_56AA);
        axi_read(32'h3C, d, r);
        check("t5_unmapped_rdata", d, 32'hDEAD_BEEF);
        check("t5_unmapped_rresp", 32'(r), 32'd2);

        // 6: reset with both responses pending
        axi_write(32'h08, 32'h0000_3C00, 4'hF, r);
        check("t6_ctrl_o_pre", 32'(ctrl_o), 32'h3C);
        bus.s_axi_awaddr  = 32'h24;
        bus.s_axi_wdata   = 32'h0BAD_F00D;
        bus.s_axi_wstrb   = 4'hF;
        bus.s_axi_araddr  = 32'h00;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        bus.s_axi_arvalid = 1'b1;
        step();
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_arvalid = 1'b0;
        step();
        check("t6_bvalid_pend", 32'(bus.s_axi_bvalid), 32'd1);
        check("t6_rvalid_pend", 32'(bus.s_axi_rvalid), 32'd1);
        rstn_i = 1'b1;
        #1;
        check("t6_rst_bvalid",  32'(bus.s_axi_bvalid),  32'd0);
        check("t6_rst_rvalid",  32'(bus.s_axi_rvalid),  32'd0);
        check("t6_rst_rdata",   bus.s_axi_rdata,        32'd0);
        check("t6_rst_awready", 32'(bus.s_axi_awready), 32'd0);
        check("t6_rst_wready",  32'(bus.s_axi_wready),  32'd0);
        check("t6_rst_arready", 32'(bus.s_axi_arready), 32'd0);
        check("t6_rst_ctrl_o",  32'(ctrl_o),            32'd0);
        step();
        step();
        rstn_i = 1'b0;
        axi_read(32'h08, d, r);
        check("t6_control", d, 32'd0);
        axi_read(32'h20, d, r);
        check("t6_scratch0", d, 32'd0);
        axi_read(32'h10, d, r);
        check("t6_wrcount", d, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
